correlator_cmd_scheduler: RTL and testbench



---
 rtl/correlator_pkg.sv | 34 +++
 rtl/lag_sweeper.sv | 87 ++++++++
 rtl/correlator_cmd_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_correlator_cmd_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/correlator_pkg.sv
// ============================================================================
// correlator_pkg
//   Shared opcodes, lag width, sweep FSM states and lag clamp helper.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package correlator_pkg;

  localparam int c_lag_w = 12;

  localparam logic [3:0] c_op_clear          = 4'd0;
  localparam logic [3:0] c_op_set_index      = 4'd1;
  localparam logic [3:0] c_op_set_leds       = 4'd2;
  localparam logic [3:0] c_op_set_baud_rate  = 4'd3;
  localparam logic [3:0] c_op_set_freq_div   = 4'd8;
  localparam logic [3:0] c_op_set_voltage    = 4'd9;
  localparam logic [3:0] c_op_set_sweep      = 4'd10;
  localparam logic [3:0] c_op_enable_capture = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SWEEP = 2'd2
  } sweep_state_t;

  // Largest lag the delay line plus jitter window can address.
  function automatic int lag_max(input int delay_size, input int jitter_size);
    return delay_size + jitter_size - 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lag_sweeper.sv
// ============================================================================
// lag_sweeper
//   Frame-stepped cross-lag sweep FSM with wrap detection (built under SWEEP_EN).
//   Revision: 1.0
// ============================================================================
`default_nettype none

`ifdef SWEEP_EN
module lag_sweeper
  import correlator_pkg::*;
#(
  parameter int LAG_W   = c_lag_w,
  parameter int LAG_MAX = 149
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_wr,
  input  logic [3:0]       cfg_data,
  input  logic             integrating,
  input  logic             frame_done,
  input  logic [7:0]       index,
  input  logic             block_step,
  input  logic [LAG_W-1:0] cur_lag,
  output logic [7:0]       sweep_idx,
  output logic             step_fire,
  output logic [LAG_W-1:0] step_lag,
  output logic             sweep_wrap
);

  sweep_state_t     r_state;
  sweep_state_t     w_next;
  logic             r_en;
  logic [2:0]       r_step;
  logic [7:0]       r_idx;
  logic             r_wrap;
  logic             w_go_idle;
  logic [LAG_W:0]   w_sum;
  logic             w_over;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_go_idle = !r_en || !integrating;
    w_sum     = {1'b0, cur_lag} + (LAG_W+1)'(r_step);
    w_over    = w_sum > (LAG_W+1)'(LAG_MAX);
    step_lag  = w_over ? '0 : w_sum[LAG_W-1:0];
    step_fire = 1'b0;
    if (w_go_idle) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_next = ST_ARMED;
        ST_ARMED: if (frame_done) w_next = ST_SWEEP;
        ST_SWEEP: step_fire = frame_done && !block_step;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // A zero step would stall the sweep, so it is promoted to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_en   <= 1'b0;
      r_step <= 3'd0;
      r_idx  <= 8'd0;
      r_wrap <= 1'b0;
    end else begin
      if (cfg_wr) begin
        r_en   <= cfg_data[0];
        r_step <= (cfg_data[3:1] == 3'd0) ? 3'd1 : cfg_data[3:1];
      end
      if (r_state == ST_IDLE && w_next == ST_ARMED) r_idx <= index;
      r_wrap <= step_fire && w_over;
    end
  end

  assign sweep_idx  = r_idx;
  assign sweep_wrap = r_wrap;

endmodule
`endif

`default_nettype wire

// File: rtl/correlator_cmd_scheduler.sv
// ============================================================================
// correlator_cmd_scheduler
//   UART command decoder holding per-input lags/flags; optional lag sweep
//   enabled by defining SWEEP_EN.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module correlator_cmd_scheduler
  import correlator_pkg::*;
#(
  parameter int NUM_INPUTS  = 8,
  parameter int DELAY_SIZE  = 150,
  parameter int JITTER_SIZE = 1,
  parameter int LAG_W       = c_lag_w
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  input  logic                        frame_done,
  output logic [NUM_INPUTS*LAG_W-1:0] cross_lag,
  output logic [NUM_INPUTS*LAG_W-1:0] auto_lag,
  output logic [NUM_INPUTS*4-1:0]     leds,
  output logic [NUM_INPUTS*4-1:0]     voltage_pwm,
  output logic [3:0]                  baud_rate,
  output logic [3:0]                  clock_divider,
  output logic                        integrating,
  output logic                        lag_changed,
  output logic                        sweep_wrap
);

  localparam int               c_lag_max   = lag_max(DELAY_SIZE, JITTER_SIZE);
  localparam logic [LAG_W-1:0] c_lag_max_v = LAG_W'(c_lag_max);
  localparam int               c_idx_w     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic [NUM_INPUTS-1:0][LAG_W-1:0] r_cross, r_auto, r_cross_stage, r_auto_stage;
  logic [NUM_INPUTS-1:0][3:0]       r_leds, r_pwm;
  logic [7:0]                       r_index;
  logic [3:0]                       r_baud, r_div;
  logic                             r_integrating, r_lag_changed;

  logic [3:0]         w_op;
  logic [c_idx_w-1:0] w_idx;
  logic               w_idx_ok;
  logic               w_dec_clear, w_dec_cap, w_dec_index, w_dec_leds, w_dec_baud;
  logic               w_dec_lag, w_dec_div, w_dec_volt;
  logic [LAG_W-1:0]   w_stage_src, w_stage_new, w_commit;

  assign w_op     = rx_data[3:0];
  assign w_idx    = r_index[c_idx_w-1:0];
  assign w_idx_ok = int'(r_index) < NUM_INPUTS;

`ifdef SWEEP_EN
  logic               w_dec_sweep;
`endif

  always_comb begin
    w_dec_clear = 1'b0;
    w_dec_cap   = 1'b0;
    w_dec_index = 1'b0;
    w_dec_leds  = 1'b0;
    w_dec_baud  = 1'b0;
    w_dec_lag   = 1'b0;
    w_dec_div   = 1'b0;
    w_dec_volt  = 1'b0;
`ifdef SWEEP_EN
    w_dec_sweep = 1'b0;
`endif
    if (rx_valid) begin
      if      (w_op == c_op_clear)          w_dec_clear = 1'b1;
      else if (w_op == c_op_enable_capture) w_dec_cap   = 1'b1;
      else if (w_op == c_op_set_index)      w_dec_index = 1'b1;
      else if (w_op == c_op_set_leds)       w_dec_leds  = 1'b1;
      else if (w_op == c_op_set_baud_rate)  w_dec_baud  = 1'b1;
`ifdef SWEEP_EN
      else if (w_op == c_op_set_sweep)      w_dec_sweep = 1'b1;
`endif
      else if (rx_data[2])                  w_dec_lag   = 1'b1;
      else if (w_op == c_op_set_freq_div)   w_dec_div   = 1'b1;
      else if (w_op == c_op_set_voltage)    w_dec_volt  = 1'b1;
    end
  end

  // Nibble merge and clamp happen combinationally so the commit lands with the byte.
  always_comb begin
    w_stage_src = rx_data[7] ? r_auto_stage[w_idx] : r_cross_stage[w_idx];
    w_stage_new = w_stage_src;
    for (int s = 0; s < 4; s++) begin
      if (rx_data[1:0] == 2'(s)) w_stage_new[s*3 +: 3] = rx_data[6:4];
    end
    w_commit = (w_stage_new > c_lag_max_v) ? c_lag_max_v : w_stage_new;
  end

`ifdef SWEEP_EN
  logic [7:0]         w_sweep_idx;
  logic [c_idx_w-1:0] w_sweep_sel;
  logic               w_sweep_ok, w_cmd_hit, w_step_fire, w_sweep_wrap;
  logic [LAG_W-1:0]   w_step_lag;

  assign w_sweep_sel = w_sweep_idx[c_idx_w-1:0];
  assign w_sweep_ok  = int'(w_sweep_idx) < NUM_INPUTS;
  assign w_cmd_hit   = (w_dec_clear || (w_dec_lag && !rx_data[7])) && w_idx_ok
                       && (r_index == w_sweep_idx);

  lag_sweeper #(
    .LAG_W   (LAG_W),
    .LAG_MAX (c_lag_max)
  ) u_lag_sweeper (
    .clk         (clk),
    .reset       (reset),
    .cfg_wr      (w_dec_sweep),
    .cfg_data    (rx_data[7:4]),
    .integrating (r_integrating),
    .frame_done  (frame_done),
    .index       (r_index),
    .block_step  (w_cmd_hit || !w_sweep_ok),
    .cur_lag     (r_cross[w_sweep_sel]),
    .sweep_idx   (w_sweep_idx),
    .step_fire   (w_step_fire),
    .step_lag    (w_step_lag),
    .sweep_wrap  (w_sweep_wrap)
  );

  assign sweep_wrap = w_sweep_wrap;
`else
  logic w_unused_frame;
  assign w_unused_frame = frame_done;
  assign sweep_wrap     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cross       <= '0;
      r_auto        <= '0;
      r_cross_stage <= '0;
      r_auto_stage  <= '0;
      r_leds        <= '0;
      r_pwm         <= '0;
      r_index       <= '0;
      r_baud        <= '0;
      r_div         <= '0;
      r_integrating <= 1'b0;
      r_lag_changed <= 1'b0;
    end else begin
      r_lag_changed <= 1'b0;
`ifdef SWEEP_EN
      if (w_step_fire) begin
        r_cross[w_sweep_sel] <= w_step_lag;
        r_lag_changed        <= 1'b1;
      end
`endif
      if (w_dec_clear && w_idx_ok) begin
        r_cross[w_idx]       <= '0;
        r_auto[w_idx]        <= '0;
        r_cross_stage[w_idx] <= '0;
        r_auto_stage[w_idx]  <= '0;
        r_lag_changed        <= 1'b1;
      end
      if (w_dec_cap)              r_integrating <= rx_data[4];
      if (w_dec_index)            r_index[{rx_data[7:6], 1'b0} +: 2] <= rx_data[5:4];
      if (w_dec_leds && w_idx_ok) r_leds[w_idx] <= rx_data[7:4];
      if (w_dec_baud)             r_baud <= rx_data[7:4];
      if (w_dec_div)              r_div <= rx_data[7:4];
      if (w_dec_volt && w_idx_ok) r_pwm[w_idx] <= rx_data[7:4];
      if (w_dec_lag && w_idx_ok) begin
        if (rx_data[7]) begin
          r_auto_stage[w_idx] <= w_stage_new;
          r_auto[w_idx]       <= w_commit;
        end else begin
          r_cross_stage[w_idx] <= w_stage_new;
          r_cross[w_idx]       <= w_commit;
        end
        r_lag_changed <= 1'b1;
      end
    end
  end

  assign cross_lag     = r_cross;
  assign auto_lag      = r_auto;
  assign leds          = r_leds;
  assign voltage_pwm   = r_pwm;
  assign baud_rate     = r_baud;
  assign clock_divider = r_div;
  assign integrating   = r_integrating;
  assign lag_changed   = r_lag_changed;

endmodule

`default_nettype wire

// File: tb/tb_correlator_cmd_scheduler.sv
// ============================================================================
// tb_correlator_cmd_scheduler
//   Directed scoreboard bench for correlator_cmd_scheduler (sweep part under SWEEP_EN).
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_correlator_cmd_scheduler;

  localparam int c_n = 8;
  localparam int c_w = 12;

  localparam int c_sel_cross = 0;
  localparam int c_sel_auto  = 1;
  localparam int c_sel_leds  = 2;
  localparam int c_sel_pwm   = 3;
  localparam int c_sel_baud  = 4;
  localparam int c_sel_div   = 5;
  localparam int c_sel_cap   = 6;
  localparam int c_sel_lchg  = 7;
  localparam int c_sel_wrap  = 8;
  localparam int c_sel_any   = 9;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       rx_data = 8'd0;
  logic             rx_valid = 1'b0;
  logic             frame_done = 1'b0;
  logic [c_n*c_w-1:0] cross_lag, auto_lag;
  logic [c_n*4-1:0] leds, voltage_pwm;
  logic [3:0]       baud_rate, clock_divider;
  logic             integrating, lag_changed, sweep_wrap;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    int          sel;
    int          arg;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];

  correlator_cmd_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .frame_done    (frame_done),
    .cross_lag     (cross_lag),
    .auto_lag      (auto_lag),
    .leds          (leds),
    .voltage_pwm   (voltage_pwm),
    .baud_rate     (baud_rate),
    .clock_divider (clock_divider),
    .integrating   (integrating),
    .lag_changed   (lag_changed),
    .sweep_wrap    (sweep_wrap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get(input int sel, input int arg);
    case (sel)
      c_sel_cross: get = {20'd0, cross_lag[arg*c_w +: c_w]};
      c_sel_auto:  get = {20'd0, auto_lag[arg*c_w +: c_w]};
      c_sel_leds:  get = leds;
      c_sel_pwm:   get = {28'd0, voltage_pwm[arg*4 +: 4]};
      c_sel_baud:  get = {28'd0, baud_rate};
      c_sel_div:   get = {28'd0, clock_divider};
      c_sel_cap:   get = {31'd0, integrating};
      c_sel_lchg:  get = {31'd0, lag_changed};
      c_sel_wrap:  get = {31'd0, sweep_wrap};
      default:     get = {31'd0, |{cross_lag, auto_lag, leds, voltage_pwm, baud_rate,
                                   clock_divider, integrating, lag_changed, sweep_wrap}};
    endcase
  endfunction

  // Monitor: compares every expectation due in the current cycle.
  always @(negedge clk) begin
    exp_t keep[$];
    logic [31:0] act;
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) begin
        checks++;
        act = get(sb[i].sel, sb[i].arg);
        if (act !== sb[i].val) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d (cycle %0d)", sb[i].name, act, sb[i].val, cyc);
        end
      end else if (sb[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d never sampled", sb[i].name, sb[i].cyc);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  task automatic exp_push(input int dly, input int sel, input int arg,
                          input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = cyc + dly; e.sel = sel; e.arg = arg; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frame();
    frame_done = 1'b1;
    @(posedge clk); #1;
    frame_done = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    exp_push(0, c_sel_any, 0, 0, "reset_all_zero");
    reset = 1'b0;
    idle(1);

    // Cross lag nibbles on input 1
    send(8'h11);
    exp_push(1, c_sel_cross, 1, 5, "cross1_slice0");
    exp_push(1, c_sel_lchg, 0, 1, "lagchg_first");
    send(8'h54);
    exp_push(1, c_sel_cross, 1, 13, "cross1_slice1");
    exp_push(1, c_sel_lchg, 0, 1, "lagchg_second");
    exp_push(2, c_sel_lchg, 0, 0, "lagchg_single_cycle");
    send(8'h15);

    // Auto lag clamp and CLEAR on input 2
    send(8'h21);
    exp_push(1, c_sel_auto, 2, 7, "auto2_7");
    send(8'hF4);
    exp_push(1, c_sel_auto, 2, 63, "auto2_63");
    send(8'hF5);
    exp_push(1, c_sel_auto, 2, 149, "auto2_clamp");
    send(8'hF6);
    exp_push(1, c_sel_cross, 2, 3, "cross2_3");
    send(8'h34);
    exp_push(1, c_sel_auto, 2, 0, "clear_auto2");
    exp_push(1, c_sel_cross, 2, 0, "clear_cross2");
    exp_push(1, c_sel_cross, 1, 13, "clear_keeps_cross1");
    exp_push(1, c_sel_lchg, 0, 1, "clear_lagchg");
    send(8'h00);
    exp_push(1, c_sel_auto, 2, 1, "clear_zeroed_staging");
    send(8'h94);

    // Per-input and global settings
    exp_push(1, c_sel_leds, 0, 32'h0000_0500, "leds2_5");
    send(8'h52);
    exp_push(1, c_sel_pwm, 2, 7, "pwm2_7");
    send(8'h79);
    exp_push(1, c_sel_div, 0, 6, "clkdiv_6");
    send(8'h68);
    send(8'h0B);
    exp_push(0, c_sel_div, 0, 6, "ignored_opcode");

    // Index 9 is out of range: per-input writes dropped, globals apply
    send(8'h11);
    send(8'h61);
    exp_push(1, c_sel_leds, 0, 32'h0000_0500, "leds_drop_idx9");
    send(8'hA2);
    exp_push(1, c_sel_lchg, 0, 0, "lag_drop_idx9");
    send(8'h74);
    exp_push(1, c_sel_baud, 0, 3, "baud_3");
    send(8'h33);
    exp_push(1, c_sel_cap, 0, 1, "capture_on");
    send(8'h1D);
    exp_push(1, c_sel_cap, 0, 0, "capture_off");
    send(8'h0D);
    idle(2);

`ifdef SWEEP_EN
    exp_push(1, c_sel_any, 0, 0, "reset_before_sweep");
    pulse_reset();
    send(8'h1D);
    send(8'h5A);
    idle(3);
    exp_push(1, c_sel_cross, 0, 0, "armed_frame_ignored");
    exp_push(1, c_sel_lchg, 0, 0, "armed_no_lagchg");
    frame();
    idle(1);
    for (int k = 1; k <= 74; k++) begin
      exp_push(1, c_sel_cross, 0, 2 * k, "sweep_step");
      exp_push(1, c_sel_lchg, 0, 1, "sweep_lagchg");
      frame();
      idle(1);
    end
    exp_push(1, c_sel_cross, 0, 0, "sweep_wrap_lag");
    exp_push(1, c_sel_wrap, 0, 1, "sweep_wrap_pulse");
    exp_push(2, c_sel_wrap, 0, 0, "sweep_wrap_single");
    frame();
    idle(1);
    exp_push(1, c_sel_cross, 0, 2, "sweep_after_wrap_2");
    frame();
    idle(1);
    exp_push(1, c_sel_cross, 0, 4, "sweep_after_wrap_4");
    frame();
    idle(1);
    // Command and frame boundary together: command wins, step skipped
    exp_push(1, c_sel_cross, 0, 3, "collision_cmd_wins");
    rx_data = 8'h34; rx_valid = 1'b1; frame_done = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'd0; frame_done = 1'b0;
    idle(1);
    exp_push(1, c_sel_cross, 0, 5, "step_after_collision");
    frame();
    idle(1);
    exp_push(1, c_sel_any, 0, 0, "reset_mid_sweep");
    pulse_reset();
    idle(1);
    exp_push(1, c_sel_cross, 0, 0, "idle_after_reset");
    exp_push(1, c_sel_wrap, 0, 0, "no_wrap_after_reset");
    frame();
    idle(2);
`else
    send(8'h1D);
    exp_push(1, c_sel_cross, 0, 0, "sweep_op_ignored");
    send(8'h5A);
    idle(2);
    exp_push(1, c_sel_cross, 0, 0, "no_sweep_step");
    exp_push(1, c_sel_wrap, 0, 0, "wrap_tied_low");
    exp_push(1, c_sel_lchg, 0, 0, "no_sweep_lagchg");
    frame();
    idle(2);
`endif

    idle(3);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
